// File: rtl/shift_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// shift_stage: two-register-stage SLL/SRL/SRA/ROR shifter with valid/ready
// handshake; ROR enabled by SHIFT_STAGE_ROTATE_EN.  Revision 1.0
// ----------------------------------------------------------------------------
module shift_stage #(
  parameter int N = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_op,
  input  logic [N-1:0]         in_a,
  input  logic [$clog2(N)-1:0] in_shamt,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N-1:0]         out_result,
  output logic [1:0]           out_op,
  output logic [15:0]          ops_done
);

  localparam int         SW      = $clog2(N);
  localparam logic [1:0] OP_SLL  = 2'b00;
  localparam logic [1:0] OP_SRL  = 2'b01;
  localparam logic [1:0] OP_SRA  = 2'b10;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  logic          s1_valid_q, s1_valid_d;
  logic [1:0]    s1_op_q,    s1_op_d;
  logic [N-1:0]  s1_a_q,     s1_a_d;
  logic [SW-1:0] s1_shamt_q, s1_shamt_d;
  logic          s2_valid_q, s2_valid_d;
  logic [N-1:0]  s2_result_q, s2_result_d;
  logic [1:0]    s2_op_q,    s2_op_d;
  logic [15:0]   ops_done_q, ops_done_d;

  logic          s2_adv;
  logic          s1_adv;
  logic          in_xfer;
  logic          out_xfer;
  logic [N-1:0]  shift_res;
  logic [N-1:0]  ror_res;

  // Log-depth barrel shifters: stage k shifts by 2**k when shamt bit k is set.
  logic [N-1:0] sll_stg [0:SW];
  logic [N-1:0] srl_stg [0:SW];
  logic [N-1:0] sra_stg [0:SW];

  assign sll_stg[0] = s1_a_q;
  assign srl_stg[0] = s1_a_q;
  assign sra_stg[0] = s1_a_q;

`ifdef SHIFT_STAGE_ROTATE_EN
  logic [N-1:0] ror_stg [0:SW];
  assign ror_stg[0] = s1_a_q;
  assign ror_res    = ror_stg[SW];
`else
  // Without rotate support op 11 still flows through, returning the operand.
  assign ror_res = s1_a_q;
`endif

  generate
    for (genvar k = 0; k < SW; k++) begin : g_stage
      localparam int STEP = 1 << k;
      assign sll_stg[k+1] = s1_shamt_q[k] ?
          {sll_stg[k][N-1-STEP:0], {STEP{1'b0}}} : sll_stg[k];
      assign srl_stg[k+1] = s1_shamt_q[k] ?
          {{STEP{1'b0}}, srl_stg[k][N-1:STEP]} : srl_stg[k];
      // MSB of every stage is still the original sign bit, so fill from it.
      assign sra_stg[k+1] = s1_shamt_q[k] ?
          {{STEP{sra_stg[k][N-1]}}, sra_stg[k][N-1:STEP]} : sra_stg[k];
`ifdef SHIFT_STAGE_ROTATE_EN
      assign ror_stg[k+1] = s1_shamt_q[k] ?
          {ror_stg[k][STEP-1:0], ror_stg[k][N-1:STEP]} : ror_stg[k];
`endif
    end
  endgenerate

  always_comb begin
    shift_res = ror_res;
    case (s1_op_q)
      OP_SLL:  shift_res = sll_stg[SW];
      OP_SRL:  shift_res = srl_stg[SW];
      OP_SRA:  shift_res = sra_stg[SW];
      default: shift_res = ror_res;
    endcase
  end

  // Output valid is masked by reset so nothing can transfer while rst is low.
  assign out_valid  = s2_valid_q & rst;
  assign out_result = s2_result_q;
  assign out_op     = s2_op_q;
  assign ops_done   = ops_done_q;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = s1_valid_q && s2_adv;
  assign in_ready = !s1_valid_q || s2_adv;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_a_d      = s1_a_q;
    s1_shamt_d  = s1_shamt_q;
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_op_d     = s2_op_q;
    ops_done_d  = ops_done_q;

    if (in_xfer) begin
      s1_valid_d = 1'b1;
      s1_op_d    = in_op;
      s1_a_d     = in_a;
      s1_shamt_d = in_shamt;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
    end
    if (s1_adv) begin
      s2_result_d = shift_res;
      s2_op_d     = s1_op_q;
    end

    if (out_xfer && (ops_done_q != CNT_MAX)) begin
      ops_done_d = ops_done_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= 2'b00;
      s1_a_q      <= '0;
      s1_shamt_q  <= '0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_op_q     <= 2'b00;
      ops_done_q  <= 16'd0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_a_q      <= s1_a_d;
      s1_shamt_q  <= s1_shamt_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_op_q     <= s2_op_d;
      ops_done_q  <= ops_done_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_shift_stage: randomized + directed bench against a queue-based model.
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_shift_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_a;
  logic [4:0]  in_shamt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [1:0]  out_op;
  logic [15:0] ops_done;

  shift_stage #(.N(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_shamt  (in_shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .out_op    (out_op),
    .ops_done  (ops_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic [1:0]  op;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] model_cnt = 16'd0;
  int          cyc       = 0;
  int          n_checks  = 0;
  int          n_errors  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference shifter written bit-by-bit from the operation definitions.
  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] a,
                                            input logic [4:0] sh);
    logic [31:0] r;
    r = a;
    for (int i = 0; i < 32; i++) begin
      case (op)
        2'b00: r[i] = (i >= int'(sh)) ? a[i - int'(sh)] : 1'b0;
        2'b01: r[i] = (i + int'(sh) < 32) ? a[i + int'(sh)] : 1'b0;
        2'b10: r[i] = (i + int'(sh) < 32) ? a[i + int'(sh)] : a[31];
`ifdef SHIFT_STAGE_ROTATE_EN
        default: r[i] = a[(i + int'(sh)) % 32];
`else
        default: r[i] = a[i];
`endif
      endcase
    end
    return r;
  endfunction

  // Negedge observation: item count in flight (max 2) and head age decide
  // the handshake outputs; queue head decides the data.
  task automatic observe(output logic took);
    logic exp_ov;
    took = 1'b0;
    cyc++;
    if (!rst) begin
      check_eq("oval_in_rst", 32'(out_valid), 32'd0);
      exp_q.delete();
      model_cnt = 16'd0;
    end else begin
      check_eq("in_ready", 32'(in_ready), 32'((exp_q.size() < 2) || out_ready));
      exp_ov = (exp_q.size() > 0) && (cyc - exp_q[0].cyc >= 2);
      check_eq("out_valid", 32'(out_valid), 32'(exp_ov));
      check_eq("ops_done", 32'(ops_done), 32'(model_cnt));
      if (out_valid && exp_q.size() > 0) begin
        check_eq("out_result", out_result, exp_q[0].res);
        check_eq("out_op", 32'(out_op), 32'(exp_q[0].op));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back('{res: ref_shift(in_op, in_a, in_shamt), op: in_op, cyc: cyc});
        took = 1'b1;
      end
    end
  endtask

  // Entered and left at posedge+1.
  task automatic run_cycle(input logic v, input logic [1:0] op, input logic [31:0] a,
                           input logic [4:0] sh, input logic ordy, output logic took);
    in_valid  = v;
    in_op     = op;
    in_a      = a;
    in_shamt  = sh;
    out_ready = ordy;
    @(negedge clk);
    observe(took);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    logic t;
    run_cycle(1'b0, 2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)), ordy, t);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle(1'b1);
    check_eq("drained", 32'(exp_q.size()), 32'd0);
  endtask

  // Offer one request until accepted, bounded.
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [4:0] sh,
                      input logic ordy);
    logic t;
    t = 1'b0;
    for (int i = 0; i < 10 && !t; i++) run_cycle(1'b1, op, a, sh, ordy, t);
    check_eq("send_accepted", 32'(t), 32'd1);
  endtask

  initial begin
    logic t;
    rst = 1'b0;
    in_valid = 1'b0; in_op = 2'b00; in_a = 32'h0; in_shamt = 5'd0; out_ready = 1'b0;
    @(posedge clk); #1;
    idle(1'b0);
    idle(1'b1);
    rst = 1'b1;

    // Reset state: first cycle after release
    idle(1'b0);
    check_eq("rst_result", out_result, 32'h0);
    check_eq("rst_op", 32'(out_op), 32'd0);
    check_eq("rst_ops_done", 32'(ops_done), 32'd0);

    // Backpressure: two captured, third stalls, then all three emerge in order
    run_cycle(1'b1, 2'b00, 32'h0000_00A5, 5'd3, 1'b0, t);
    check_eq("bp_take1", 32'(t), 32'd1);
    run_cycle(1'b1, 2'b01, 32'hA500_0000, 5'd7, 1'b0, t);
    check_eq("bp_take2", 32'(t), 32'd1);
    for (int i = 0; i < 3; i++) begin
      run_cycle(1'b1, 2'b10, 32'h8000_1234, 5'd9, 1'b0, t);
      check_eq("bp_stall3", 32'(t), 32'd0);
    end
    send(2'b10, 32'h8000_1234, 5'd9, 1'b1);
    drain();
    check_eq("bp_ops_done3", 32'(ops_done), 32'd3);

    // SRA sign fill with 2-cycle latency
    send(2'b10, 32'h8000_0000, 5'd4, 1'b1);
    idle(1'b1);
    check_eq("sra_valid", 32'(out_valid), 32'd1);
    check_eq("sra_result", out_result, 32'hF800_0000);
    check_eq("sra_op", 32'(out_op), 32'd2);
    drain();

    // Back-to-back SLL 31 / SRL 28
    send(2'b00, 32'h0000_0001, 5'd31, 1'b1);
    send(2'b01, 32'hF000_0000, 5'd28, 1'b1);
    check_eq("b2b_first", out_result, 32'h8000_0000);
    idle(1'b1);
    check_eq("b2b_second", out_result, 32'h0000_000F);
    drain();

    // ROR by one (operand passes through when rotate is compiled out)
    send(2'b11, 32'h0000_0001, 5'd1, 1'b1);
    idle(1'b1);
`ifdef SHIFT_STAGE_ROTATE_EN
    check_eq("ror_result", out_result, 32'h8000_0000);
`else
    check_eq("ror_result", out_result, 32'h0000_0001);
`endif
    check_eq("ror_op", 32'(out_op), 32'd3);
    drain();

    // shamt 0 returns operand for every op
    for (int op = 0; op < 4; op++) send(2'(op), 32'hDEAD_BEEF, 5'd0, 1'b1);
    drain();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [4:0] sh;
      sh = ($urandom_range(0, 7) == 0) ? 5'd0 :
           ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
      run_cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom, sh,
                $urandom_range(0, 3) != 0, t);
    end
    drain();

    // Reset while both stages are full
    send(2'b00, 32'h1234_5678, 5'd4, 1'b0);
    send(2'b01, 32'h1234_5678, 5'd4, 1'b0);
    check_eq("full_before_rst", 32'(exp_q.size()), 32'd2);
    rst = 1'b0;
    idle(1'b1);
    rst = 1'b1;
    idle(1'b0);
    check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_ops_done", 32'(ops_done), 32'd0);

    // Saturation: preload counter, then push past the limit
    force dut.ops_done_q = 16'hFFFE;
    model_cnt = 16'hFFFE;
    idle(1'b1);
    release dut.ops_done_q;
    for (int i = 0; i < 4; i++) send(2'($urandom_range(0, 3)), $urandom, 5'($urandom_range(0, 31)), 1'b1);
    drain();
    check_eq("sat_ops_done", 32'(ops_done), 32'h0000_FFFF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/shift_stage.md
SHIFT_STAGE -- requirements
Module: shift_stage

Interface
REQ-001 SHALL have parameter N, default 32, meaning data width; only N=32 is required to work.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset that is synchronous and active-low.
REQ-004 SHALL have port in_valid, input, 1, request present.
REQ-005 SHALL have port in_ready, output, 1, stage can accept a request this cycle.
REQ-006 SHALL have port in_op, input, 2, operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
REQ-007 SHALL have port in_a, input, N, operand to shift.
REQ-008 SHALL have port in_shamt, input, $clog2(N), shift amount.
REQ-009 SHALL have port out_valid, output, 1, result present.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts the result.
REQ-011 SHALL have port out_result, output, N, shifted value.
REQ-012 SHALL have port out_op, output, 2, op that produced out_result.
REQ-013 SHALL have port ops_done, output, 16, saturating count of results accepted downstream.

Function
REQ-014 SHALL treat a transfer as occurring on a cycle where valid and ready are both high on the same port.
REQ-015 SHALL implement two register stages: S1 (captured op, operand, shamt) and S2 (result, op).
REQ-016 SHALL compute the S2 result combinationally from S1 using logical-left, logical-right and arithmetic-right shifters.
REQ-017 SHALL, for SRA, fill vacated high bits with in_a[N-1].
REQ-018 SHALL, for SLL and SRL, fill vacated bits with zero.
REQ-019 SHALL, for shamt 0, return the operand unchanged for every op.
REQ-020 SHALL have a latency of exactly 2 cycles from input transfer to out_valid high when out_ready is held high.
REQ-021 SHALL sustain a throughput of one transfer per cycle when out_ready is held high.
REQ-022 SHALL advance S2 when S2 is empty or an output transfer occurs in the same cycle.
REQ-023 SHALL advance S1 into S2 when S1 is valid and S2 advances.
REQ-024 SHALL drive in_ready = !S1_valid || S2_advances, combinationally with no dependency on in_valid.
REQ-025 SHALL, when full (S1 and S2 valid, out_ready low), hold in_ready low and keep all stored data stable.
REQ-026 SHALL, on a simultaneous input and output transfer while full, accept the new request with no loss or duplication.
REQ-027 SHALL keep out_result and out_op stable while out_valid is high and out_ready is low.
REQ-028 SHALL increment ops_done by 1 per output transfer and saturate at 16'hFFFF with no wrap-around.
REQ-029 SHALL ignore in_op, in_a and in_shamt on cycles with no input transfer.

Reset
REQ-030 SHALL, while rst is low at a clock edge, clear S1_valid, S2_valid and ops_done to 0 and drive out_result and out_op to 0.
REQ-031 SHALL drive in_ready to 1 during the first cycle after reset is released.
REQ-032 SHALL discard all in-flight requests if reset is asserted mid-operation, with no output transfer occurring while rst is low.
REQ-033 SHALL reset all state including data registers; no output is left undefined after reset.

Configuration
REQ-034 SHALL gate the ROR operation with macro SHIFT_STAGE_ROTATE_EN.
REQ-035 SHALL, when SHIFT_STAGE_ROTATE_EN is defined, compute op 11 as rotate right by shamt, with bit i of the result equal to in_a[(i+shamt) mod N].
REQ-036 SHALL, when SHIFT_STAGE_ROTATE_EN is undefined, still accept op 11 but return the operand unchanged, with out_op=11 and identical handshake and latency.

Verification
REQ-037 SHALL cover: SRA, a=0x80000000, shamt=4, out_ready=1 -> out_result=0xF8000000 exactly 2 cycles later, out_op=10.
REQ-038 SHALL cover: SLL a=0x00000001 shamt=31, then SRL a=0xF0000000 shamt=28, on back-to-back cycles -> results 0x80000000 then 0x0000000F on consecutive cycles.
REQ-039 SHALL cover: out_ready=0 with 3 requests offered -> 2 captured, in_ready low on the 3rd; then out_ready=1 -> all 3 emerge in order with none lost; ops_done=3.
REQ-040 SHALL cover: rst low for 1 cycle while both stages are full -> out_valid=0, in_ready=1, ops_done=0 on the next cycle.
REQ-041 SHALL cover: ROR a=0x00000001 shamt=1 -> 0x80000000 with SHIFT_STAGE_ROTATE_EN defined, and 0x00000001 without it.
REQ-042 SHALL cover: preload ops_done to 0xFFFE via 2 extra transfers forced through a bench hook -> ops_done stays at 0xFFFF after further transfers.
